pipeline_hazard_ctrl: RTL and testbench

Hazard and stall controller for the five-stage pipeline. It drives the enable/flush pairs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC write enable. Its inputs are cache hit signals, load-use comparisons, branch/jump resolution and the halt flag. It also tracks data-memory wait cycles for a timeout monitor and keeps saturating stall/flush statistics counters.

---
 rtl/pipeline_hazard_ctrl_if.sv | 47 ++++
 rtl/pipeline_hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status flowing in, register controls and
// monitor/statistics outputs flowing back to the datapath.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             ihit;
  logic             dhit;
  logic             dREN_EX_MEM;
  logic             dWEN_EX_MEM;
  logic             dREN_ID_EX;
  logic [4:0]       Rt_ID_EX;
  logic [4:0]       Rs_IF_ID;
  logic [4:0]       Rt_IF_ID;
  logic             branch_taken_MEM;
  logic             jump_ID;
  logic             halt_MEM_WB;

  logic             pc_enable;
  logic             enable_IF_ID;
  logic             flush_IF_ID;
  logic             enable_ID_EX;
  logic             flush_ID_EX;
  logic             enable_EX_MEM;
  logic             flush_EX_MEM;
  logic             enable_MEM_WB;
  logic             flush_MEM_WB;
  logic             halted;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output ihit, dhit, dREN_EX_MEM, dWEN_EX_MEM, dREN_ID_EX, Rt_ID_EX,
           Rs_IF_ID, Rt_IF_ID, branch_taken_MEM, jump_ID, halt_MEM_WB,
    input  pc_enable, enable_IF_ID, flush_IF_ID, enable_ID_EX, flush_ID_EX,
           enable_EX_MEM, flush_EX_MEM, enable_MEM_WB, flush_MEM_WB,
           halted, mem_timeout, stall_cycles, flush_events
  );

  modport slave (
    input  ihit, dhit, dREN_EX_MEM, dWEN_EX_MEM, dREN_ID_EX, Rt_ID_EX,
           Rs_IF_ID, Rt_IF_ID, branch_taken_MEM, jump_ID, halt_MEM_WB,
    output pc_enable, enable_IF_ID, flush_IF_ID, enable_ID_EX, flush_ID_EX,
           enable_EX_MEM, flush_EX_MEM, enable_MEM_WB, flush_MEM_WB,
           halted, mem_timeout, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard/stall controller: prioritised enable/flush
// generation, data-wait timeout monitor and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input logic                   CLK,
  input logic                   RST,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int unsigned DW = $clog2(TIMEOUT) + 1;
  localparam logic [DW-1:0] TO_LAST = DW'(TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;

  state_t           state, next_state;
  logic [DW-1:0]    dwait_cnt;
  logic             halted_q, timeout_q;
  logic [CNT_W-1:0] stall_q, flush_q;

  logic mem_req, dstall, load_use, branch_rule;
  logic pc_en, en_ifid, fl_ifid, en_idex, fl_idex;
  logic en_exmem, fl_exmem, en_memwb, fl_memwb;

  assign mem_req  = hz.dREN_EX_MEM | hz.dWEN_EX_MEM;
  assign dstall   = mem_req & ~hz.dhit;
  assign load_use = hz.dREN_ID_EX & (hz.Rt_ID_EX != 5'd0) &
                    ((hz.Rt_ID_EX == hz.Rs_IF_ID) | (hz.Rt_ID_EX == hz.Rt_IF_ID));

  always_comb begin
    pc_en       = 1'b1;
    en_ifid     = 1'b1;  fl_ifid  = 1'b0;
    en_idex     = 1'b1;  fl_idex  = 1'b0;
    en_exmem    = 1'b1;  fl_exmem = 1'b0;
    en_memwb    = 1'b1;  fl_memwb = 1'b0;
    branch_rule = 1'b0;

    if (RST) begin
      pc_en    = 1'b0;
      en_ifid  = 1'b0;  fl_ifid  = 1'b1;
      en_idex  = 1'b0;  fl_idex  = 1'b1;
      en_exmem = 1'b0;  fl_exmem = 1'b1;
      en_memwb = 1'b0;  fl_memwb = 1'b1;
    end else if (state == HALT || (state == RUN && hz.halt_MEM_WB)) begin
      pc_en    = 1'b0;
      en_ifid  = 1'b0;
      en_idex  = 1'b0;
      en_exmem = 1'b0;
      en_memwb = 1'b0;
    end else if (dstall) begin
      // MEM/WB takes a bubble so the frozen instruction does not write back twice
      pc_en    = 1'b0;
      en_ifid  = 1'b0;
      en_idex  = 1'b0;
      en_exmem = 1'b0;
      en_memwb = 1'b0;  fl_memwb = 1'b1;
    end else if (hz.branch_taken_MEM) begin
      branch_rule = 1'b1;
      en_ifid  = 1'b0;  fl_ifid  = 1'b1;
      en_idex  = 1'b0;  fl_idex  = 1'b1;
      en_exmem = 1'b0;  fl_exmem = 1'b1;
    end else if (load_use) begin
      pc_en    = 1'b0;
      en_ifid  = 1'b0;
      en_idex  = 1'b0;  fl_idex  = 1'b1;
    end else if (hz.jump_ID) begin
      en_ifid  = 1'b0;  fl_ifid  = 1'b1;
    end else if (!hz.ihit) begin
      pc_en    = 1'b0;
      en_ifid  = 1'b0;  fl_ifid  = 1'b1;
    end

    next_state = state;
    case (state)
      RUN: begin
        if (hz.halt_MEM_WB) next_state = HALT;
        else if (dstall)    next_state = DWAIT;
      end
      DWAIT:   if (hz.dhit) next_state = RUN;
      HALT:    next_state = HALT;
      default: next_state = RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= RUN;
      dwait_cnt <= '0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state <= next_state;
      if (state == RUN && next_state == DWAIT)
        dwait_cnt <= '0;
      else if (state == DWAIT && dwait_cnt != '1)
        dwait_cnt <= dwait_cnt + 1'b1;
      if (state == DWAIT && dwait_cnt == TO_LAST)
        timeout_q <= 1'b1;
      if (state == RUN && hz.halt_MEM_WB)
        halted_q <= 1'b1;
      if (!pc_en && state != HALT && stall_q != '1)
        stall_q <= stall_q + 1'b1;
      if (branch_rule && flush_q != '1)
        flush_q <= flush_q + 1'b1;
    end
  end

  assign hz.pc_enable     = pc_en;
  assign hz.enable_IF_ID  = en_ifid;
  assign hz.flush_IF_ID   = fl_ifid;
  assign hz.enable_ID_EX  = en_idex;
  assign hz.flush_ID_EX   = fl_idex;
  assign hz.enable_EX_MEM = en_exmem;
  assign hz.flush_EX_MEM  = fl_exmem;
  assign hz.enable_MEM_WB = en_memwb;
  assign hz.flush_MEM_WB  = fl_memwb;
  assign hz.halted        = halted_q;
  assign hz.mem_timeout   = timeout_q;
  assign hz.stall_cycles  = stall_q;
  assign hz.flush_events  = flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with TIMEOUT=4 and 4-bit counters.
module tb_pipeline_hazard_ctrl;
  logic CLK = 1'b0;
  logic RST;

  pipeline_hazard_ctrl_if #(.CNT_W(4)) bus ();

  pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .hz  (bus)
  );

  always #5 CLK = ~CLK;

  // {pc, en_ifid, fl_ifid, en_idex, fl_idex, en_exmem, fl_exmem, en_memwb, fl_memwb}
  localparam logic [8:0] C_RUN   = 9'b1_10_10_10_10;
  localparam logic [8:0] C_RST   = 9'b0_01_01_01_01;
  localparam logic [8:0] C_HALT  = 9'b0_00_00_00_00;
  localparam logic [8:0] C_DSTL  = 9'b0_00_00_00_01;
  localparam logic [8:0] C_BR    = 9'b1_01_01_01_10;
  localparam logic [8:0] C_LU    = 9'b0_00_01_10_10;
  localparam logic [8:0] C_JMP   = 9'b1_01_10_10_10;
  localparam logic [8:0] C_NOI   = 9'b0_01_10_10_10;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ctl();
    return {bus.pc_enable, bus.enable_IF_ID, bus.flush_IF_ID, bus.enable_ID_EX,
            bus.flush_ID_EX, bus.enable_EX_MEM, bus.flush_EX_MEM,
            bus.enable_MEM_WB, bus.flush_MEM_WB};
  endfunction

  task automatic idle();
    bus.ihit = 1'b1;  bus.dhit = 1'b0;
    bus.dREN_EX_MEM = 1'b0;  bus.dWEN_EX_MEM = 1'b0;  bus.dREN_ID_EX = 1'b0;
    bus.Rt_ID_EX = 5'd0;  bus.Rs_IF_ID = 5'd0;  bus.Rt_IF_ID = 5'd0;
    bus.branch_taken_MEM = 1'b0;  bus.jump_ID = 1'b0;  bus.halt_MEM_WB = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    idle();
    tick();
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    idle();
    #1;
    check("rst_ctl", 32'(ctl()), 32'(C_RST));
    tick();
    RST = 1'b0;
    #1;
    check("rst_halted", 32'(bus.halted), 0);
    check("rst_timeout", 32'(bus.mem_timeout), 0);
    check("rst_stall", 32'(bus.stall_cycles), 0);
    check("rst_flush", 32'(bus.flush_events), 0);

    for (int i = 0; i < 10; i++) begin
      check("idle_ctl", 32'(ctl()), 32'(C_RUN));
      tick();
    end
    check("idle_stall", 32'(bus.stall_cycles), 0);

    // load-use via Rs, suppressed for r0, then via Rt
    bus.dREN_ID_EX = 1'b1;  bus.Rt_ID_EX = 5'd5;  bus.Rs_IF_ID = 5'd5;
    #1 check("lu_rs_ctl", 32'(ctl()), 32'(C_LU));
    tick();
    check("lu_rs_stall", 32'(bus.stall_cycles), 1);
    bus.Rt_ID_EX = 5'd0;  bus.Rs_IF_ID = 5'd0;
    #1 check("lu_r0_ctl", 32'(ctl()), 32'(C_RUN));
    tick();
    check("lu_r0_stall", 32'(bus.stall_cycles), 1);
    bus.Rt_ID_EX = 5'd7;  bus.Rt_IF_ID = 5'd7;
    #1 check("lu_rt_ctl", 32'(ctl()), 32'(C_LU));
    tick();
    check("lu_rt_stall", 32'(bus.stall_cycles), 2);
    idle();

    bus.jump_ID = 1'b1;  bus.ihit = 1'b0;
    #1 check("jump_ctl", 32'(ctl()), 32'(C_JMP));
    tick();
    check("jump_stall", 32'(bus.stall_cycles), 2);
    bus.jump_ID = 1'b0;
    #1 check("noihit_ctl", 32'(ctl()), 32'(C_NOI));
    tick();
    check("noihit_stall", 32'(bus.stall_cycles), 3);

    // three-cycle data stall; halt during DWAIT must be ignored
    do_reset();
    bus.dREN_EX_MEM = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.halt_MEM_WB = (i == 2);
      #1 check("dstall_ctl", 32'(ctl()), 32'(C_DSTL));
      tick();
      check("dstall_cnt", 32'(bus.stall_cycles), 32'(i));
      check("dstall_nohalt", 32'(bus.halted), 0);
    end
    bus.halt_MEM_WB = 1'b0;  bus.dhit = 1'b1;
    #1 check("dhit_ctl", 32'(ctl()), 32'(C_RUN));
    tick();
    check("dhit_stall", 32'(bus.stall_cycles), 3);
    check("dhit_notimeout", 32'(bus.mem_timeout), 0);
    idle();

    // timeout: first stall cycle is in RUN, then 4 DWAIT cycles
    do_reset();
    bus.dREN_EX_MEM = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      #1 check("to_ctl", 32'(ctl()), 32'(C_DSTL));
      tick();
      if (i == 4) check("to_early", 32'(bus.mem_timeout), 0);
    end
    check("to_set", 32'(bus.mem_timeout), 1);
    check("to_stall", 32'(bus.stall_cycles), 5);
    bus.dhit = 1'b1;
    tick();
    idle();
    tick();
    check("to_sticky", 32'(bus.mem_timeout), 1);

    // branch outranks load-use and ~ihit, but not dstall
    do_reset();
    bus.branch_taken_MEM = 1'b1;  bus.ihit = 1'b0;
    bus.dREN_ID_EX = 1'b1;  bus.Rt_ID_EX = 5'd5;  bus.Rs_IF_ID = 5'd5;
    #1 check("br_ctl", 32'(ctl()), 32'(C_BR));
    tick();
    check("br_flush", 32'(bus.flush_events), 1);
    check("br_stall", 32'(bus.stall_cycles), 0);
    bus.dREN_EX_MEM = 1'b1;
    #1 check("br_dstall_ctl", 32'(ctl()), 32'(C_DSTL));
    tick();
    check("br_dstall_flush", 32'(bus.flush_events), 1);
    bus.dhit = 1'b1;
    #1 check("br_dhit_ctl", 32'(ctl()), 32'(C_BR));
    tick();
    check("br_dhit_flush", 32'(bus.flush_events), 2);
    idle();

    // halt
    do_reset();
    bus.halt_MEM_WB = 1'b1;
    #1 check("halt_ctl", 32'(ctl()), 32'(C_HALT));
    tick();
    check("halt_set", 32'(bus.halted), 1);
    bus.halt_MEM_WB = 1'b0;  bus.dREN_EX_MEM = 1'b1;  bus.jump_ID = 1'b1;
    #1 check("halt_hold_ctl", 32'(ctl()), 32'(C_HALT));
    tick();
    check("halt_sticky", 32'(bus.halted), 1);
    check("halt_stall", 32'(bus.stall_cycles), 1);
    RST = 1'b1;
    #1 check("halt_rst_ctl", 32'(ctl()), 32'(C_RST));
    tick();
    RST = 1'b0;
    idle();
    #1 check("halt_exit_ctl", 32'(ctl()), 32'(C_RUN));
    check("halt_cleared", 32'(bus.halted), 0);
    check("halt_rst_stall", 32'(bus.stall_cycles), 0);

    // reset mid-DWAIT returns to RUN (halt is honoured again)
    bus.dREN_EX_MEM = 1'b1;
    tick();
    tick();
    do_reset();
    bus.halt_MEM_WB = 1'b1;
    #1 check("dw_rst_run", 32'(ctl()), 32'(C_HALT));
    check("dw_rst_stall", 32'(bus.stall_cycles), 0);
    idle();

    // saturation
    do_reset();
    bus.ihit = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("sat_stall", 32'(bus.stall_cycles), 15);
    do_reset();
    bus.branch_taken_MEM = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("sat_flush", 32'(bus.flush_events), 15);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
